// File: rtl/silife_max7219_chain.sv
// Streams one frame of row data onto a MAX7219 daisy chain. Before the rows it sends
// an optional init sequence and an optional intensity update.
module silife_max7219_chain #(
  parameter int NUM_DEVICES = 4,
  parameter int CLK_DIV     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     reinit,
  input  logic [3:0]               intensity,
  output logic [2:0]               row_addr,
  input  logic [NUM_DEVICES*8-1:0] row_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     max7219_cs,
  output logic                     max7219_sck,
  output logic                     max7219_mosi
);

  localparam int W  = NUM_DEVICES * 16;
  localparam int BW = $clog2(W);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(2 * CLK_DIV);

  // Job index: 0..4 are the init words, 4 alone is the intensity update, 5..12 are rows 0..7.
  localparam logic [3:0] JOB_INT  = 4'd4;
  localparam logic [3:0] JOB_ROW0 = 4'd5;
  localparam logic [3:0] JOB_LAST = 4'd12;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SHIFT, GAP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      job_q, job_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic            phase_q, phase_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [3:0]      cur_int_q, cur_int_d;
  logic [3:0]      last_int_q, last_int_d;
  logic            init_needed_q, init_needed_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [2:0]      row_addr_q, row_addr_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;

  function automatic logic [15:0] cfg_word(input logic [3:0] job, input logic [3:0] cur);
    case (job)
      4'd0:    cfg_word = 16'h0C01;
      4'd1:    cfg_word = 16'h0B07;
      4'd2:    cfg_word = 16'h0900;
      4'd3:    cfg_word = 16'h0F00;
      default: cfg_word = {8'h0A, 4'h0, cur};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      job_q         <= '0;
      bit_q         <= '0;
      div_q         <= '0;
      phase_q       <= 1'b0;
      gap_q         <= '0;
      // NOTE: the shift register is small, so it is reset too; this keeps the pads deterministic.
      shift_q       <= '0;
      cur_int_q     <= '0;
      last_int_q    <= '0;
      init_needed_q <= 1'b1;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      row_addr_q    <= '0;
      cs_q          <= 1'b1;
      sck_q         <= 1'b0;
      mosi_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_q         <= job_d;
      bit_q         <= bit_d;
      div_q         <= div_d;
      phase_q       <= phase_d;
      gap_q         <= gap_d;
      shift_q       <= shift_d;
      cur_int_q     <= cur_int_d;
      last_int_q    <= last_int_d;
      init_needed_q <= init_needed_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      row_addr_q    <= row_addr_d;
      cs_q          <= cs_d;
      sck_q         <= sck_d;
      mosi_q        <= mosi_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path through this block infers a latch.
    state_d       = state_q;
    job_d         = job_q;
    bit_d         = bit_q;
    div_d         = div_q;
    phase_d       = phase_q;
    gap_d         = gap_q;
    shift_d       = shift_q;
    cur_int_d     = cur_int_q;
    last_int_d    = last_int_q;
    init_needed_d = init_needed_q;
    abort_d       = abort_q | (busy_q & ~enable);
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    row_addr_d    = row_addr_q;

    case (state_q)
      IDLE: begin
        if (start && enable && !busy_q) begin
          busy_d    = 1'b1;
          cur_int_d = intensity;
          abort_d   = 1'b0;
          state_d   = LOAD;
          if (init_needed_q) begin
            job_d         = 4'd0;
            init_needed_d = 1'b0;
          end else if (intensity != last_int_q) begin
            job_d = JOB_INT;
          end else begin
            job_d = JOB_ROW0;
          end
        end
      end
      LOAD: state_d = FETCH;
      FETCH: begin
        state_d = SHIFT;
        bit_d   = '0;
        div_d   = '0;
        phase_d = 1'b0;
        for (int d = 0; d < NUM_DEVICES; d++) begin
          if (job_q >= JOB_ROW0)
            shift_d[16*d +: 16] = {4'h0, {1'b0, row_addr_q} + 4'd1, row_data[8*d +: 8]};
          else
            shift_d[16*d +: 16] = cfg_word(job_q, cur_int_q);
        end
      end
      SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            shift_d = {shift_q[W-2:0], 1'b0};
            if (bit_q == BW'(W - 1)) begin
              state_d = GAP;
              gap_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(2 * CLK_DIV - 1)) begin
          gap_d = '0;
          if (abort_q || !enable) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (job_q == JOB_LAST) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            last_int_d   = cur_int_q;
          end else begin
            state_d = LOAD;
            job_d   = job_q + 4'd1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The address is valid throughout LOAD, so a synchronous-read memory returns the row during FETCH.
    if (state_d == LOAD && job_d >= JOB_ROW0)
      row_addr_d = 3'(job_d - JOB_ROW0);

    // A reinit in the same cycle as an accepted start is kept for the following frame.
    if (reinit)
      init_needed_d = 1'b1;
  end

  // Pad values are derived from the next state, so the pins come straight from flops.
  always_comb begin
    cs_d   = (state_d != SHIFT);
    sck_d  = (state_d == SHIFT) && phase_d;
    mosi_d = (state_d == SHIFT) && shift_d[W-1];
  end

  assign row_addr     = row_addr_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign max7219_cs   = cs_q;
  assign max7219_sck  = sck_q;
  assign max7219_mosi = mosi_q;

endmodule

// File: tb/tb_silife_max7219_chain.sv
// Bench for silife_max7219_chain with 2 devices and CLK_DIV=2. A monitor decodes the
// serial pads into windows, and each window is compared with hand-derived frame contents.
module tb_silife_max7219_chain;

  localparam int ND = 2;
  localparam int CD = 2;
  localparam int JOB_CYC = 2 + 32 * ND * CD + 2 * CD;  // 134

  logic            clk = 1'b0;
  logic            reset, enable, start, reinit;
  logic [3:0]      intensity;
  logic [2:0]      row_addr;
  logic [ND*8-1:0] row_data = '0;
  logic            busy, frame_done, max7219_cs, max7219_sck, max7219_mosi;

  silife_max7219_chain #(.NUM_DEVICES(ND), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .reinit(reinit),
    .intensity(intensity), .row_addr(row_addr), .row_data(row_data),
    .busy(busy), .frame_done(frame_done), .max7219_cs(max7219_cs),
    .max7219_sck(max7219_sck), .max7219_mosi(max7219_mosi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Frame buffer row pattern: device 1 gets 0x11*(r+1), device 0 gets 0xA0+r.
  function automatic logic [15:0] pat(input logic [2:0] r);
    logic [7:0] hi, lo;
    hi = 8'h11 * ({5'd0, r} + 8'd1);
    lo = 8'hA0 + {5'd0, r};
    return {hi, lo};
  endfunction

  function automatic logic [31:0] row_word(input logic [2:0] r);
    logic [15:0] p;
    logic [3:0]  a;
    p = pat(r);
    a = {1'b0, r} + 4'd1;
    return {4'h0, a, p[15:8], 4'h0, a, p[7:0]};
  endfunction

  // Synchronous-read frame buffer model, one cycle of latency.
  always @(posedge clk) row_data <= pat(row_addr);

  typedef struct {
    logic [31:0] word;
    int          edges;
    int          lows;
  } win_t;

  win_t        windows[$];
  logic [31:0] cur_word;
  int          cur_edges, cur_lows, done_cnt, busy_cnt;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;

  // Pad monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (reset) begin
      cur_word = '0; cur_edges = 0; cur_lows = 0;
      prev_cs = 1'b1; prev_sck = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (busy) busy_cnt++;
      if (!max7219_cs) begin
        cur_lows++;
        if (max7219_sck && !prev_sck) begin
          cur_word = {cur_word[30:0], max7219_mosi};
          cur_edges++;
        end
      end else if (!prev_cs) begin
        windows.push_back('{cur_word, cur_edges, cur_lows});
        cur_word = '0; cur_edges = 0; cur_lows = 0;
      end
      prev_cs  = max7219_cs;
      prev_sck = max7219_sck;
    end
  end

  typedef struct {
    logic [3:0] intensity;
    bit         mid_start;
    bit         mid_reinit;
    bit         exp_init;
    bit         exp_int;
    int         n_windows;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_mon();
    windows.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [31:0] exp_q[$];
    bit          got;
    int          bad;
    string       tag;
    tag = $sformatf("f%0d", idx);
    clear_mon();
    intensity = v.intensity;
    @(negedge clk);
    pulse_start();
    if (v.mid_start) begin
      repeat (100) @(negedge clk);
      pulse_start();
      check({tag, "_busy_after_extra_start"}, busy, 1);
    end
    if (v.mid_reinit) begin
      repeat (300) @(negedge clk);
      reinit = 1'b1;
      @(negedge clk);
      reinit = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    check({tag, "_frame_done_seen"}, got, 1);
    repeat (5) @(negedge clk);

    if (v.exp_init) begin
      exp_q.push_back(32'h0C01_0C01);
      exp_q.push_back(32'h0B07_0B07);
      exp_q.push_back(32'h0900_0900);
      exp_q.push_back(32'h0F00_0F00);
      exp_q.push_back({8'h0A, 4'h0, v.intensity, 8'h0A, 4'h0, v.intensity});
    end else if (v.exp_int) begin
      exp_q.push_back({8'h0A, 4'h0, v.intensity, 8'h0A, 4'h0, v.intensity});
    end
    for (int r = 0; r < 8; r++) exp_q.push_back(row_word(3'(r)));

    check({tag, "_windows"}, windows.size(), v.n_windows);
    for (int i = 0; i < exp_q.size() && i < windows.size(); i++)
      check($sformatf("%s_word%0d", tag, i), windows[i].word, exp_q[i]);
    bad = 0;
    foreach (windows[i]) if (windows[i].edges != 32 || windows[i].lows != 32 * ND * CD) bad++;
    check({tag, "_window_shape_errors"}, bad, 0);
    check({tag, "_frame_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, v.n_windows * JOB_CYC);
  endtask

  initial begin
    bit got;
    vecs[0] = '{4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 13};  // power-up init, stray start while busy
    vecs[1] = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8};   // same intensity: rows only
    vecs[2] = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 9};   // intensity change
    vecs[3] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 8};   // reinit mid-frame leaves this frame alone
    vecs[4] = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 13};  // ... and forces init here

    reset = 1'b1; enable = 1'b1; start = 1'b0; reinit = 1'b0; intensity = 4'h3;
    repeat (2) @(negedge clk);
    check("reset_cs", max7219_cs, 1);
    check("reset_sck", max7219_sck, 0);
    check("reset_mosi", max7219_mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_row_addr", row_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i], i);

    // start with enable low is ignored
    clear_mon();
    enable = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    check("disabled_start_busy", busy, 0);
    check("disabled_start_windows", windows.size(), 0);
    enable = 1'b1;

    // enable dropped during the row 2 shift: row 2 completes, no frame_done
    clear_mon();
    pulse_start();
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (windows.size() == 2 && !max7219_cs) got = 1;
    end
    check("abort_reached_row2", got, 1);
    enable = 1'b0;
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    check("abort_busy_fell", got, 1);
    repeat (3) @(negedge clk);
    check("abort_windows", windows.size(), 3);
    if (windows.size() == 3) check("abort_row2_word", windows[2].word, row_word(3'd2));
    check("abort_cs_high", max7219_cs, 1);
    check("abort_no_frame_done", done_cnt, 0);
    enable = 1'b1;

    // reset in the middle of a shift, then a full init must follow
    clear_mon();
    pulse_start();
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (!max7219_cs && max7219_sck) got = 1;
    end
    check("midreset_in_shift", got, 1);
    #2 reset = 1'b1;
    #1;
    check("midreset_cs", max7219_cs, 1);
    check("midreset_sck", max7219_sck, 0);
    check("midreset_mosi", max7219_mosi, 0);
    check("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame('{4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 13}, 5);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/silife_max7219_chain.md
Name: silife_max7219_chain

Overview:
- Parametrised driver for a daisy chain of NUM_DEVICES MAX7219 8x8 LED matrix controllers.
- Streams one full frame (8 row registers per device) from a synchronous row-read interface onto the shared CS/SCK/MOSI pins; SCK rate is configurable.
- Handles device initialisation, re-initialisation on demand and runtime intensity updates.
- Sits between the silife grid/frame buffer and the max7219_cs/sck/mosi pads (mprj_io[8..10]).

Parameters:
- NUM_DEVICES, 4: number of cascaded MAX7219s; 1..16.
- CLK_DIV, 2: SCK half-period in clk cycles; >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  block enable; start is ignored while low
- start  input  1  one-cycle pulse: begin a frame
- reinit  input  1  one-cycle pulse: force the init sequence before the next frame
- intensity  input  4  brightness value for register 0x0A
- row_addr  output  3  row being fetched (0..7)
- row_data  input  NUM_DEVICES*8  row bits; slice [8*d +: 8] belongs to device d (d=0 is nearest the MCU)
- busy  output  1  high from an accepted start until the frame ends
- frame_done  output  1  one-cycle pulse when a frame completes
- max7219_cs  output  1  chip select, active low
- max7219_sck  output  1  serial clock, idle low
- max7219_mosi  output  1  serial data

Behaviour:
- Reset values (asynchronous): cs=1, sck=0, mosi=0, busy=0, frame_done=0, row_addr=0, state=IDLE, init_needed=1, last_intensity=0.
- States: IDLE, LOAD, FETCH, SHIFT, GAP.
- IDLE: start && enable && !busy -> busy=1; sample intensity into cur_int; build the job list.
  - Init list, sent only if init_needed: 0x0C=0x01, 0x0B=0x07, 0x09=0x00, 0x0F=0x00, 0x0A=cur_int. Clears init_needed.
  - Otherwise, if cur_int != last_intensity: a single 0x0A=cur_int job.
  - Then rows r=0..7.
- start while busy: ignored. A reinit pulse at any time sets init_needed; it takes effect at the next accepted start.
- LOAD (1 cycle): drive row_addr=r for row jobs; hold the previous value for config jobs.
- FETCH (1 cycle): capture row_data on the clock edge that ends the cycle (1-cycle read latency). Build a NUM_DEVICES*16-bit shift word.
  - Row jobs: each device word = {4'h0, 4'(r+1), row_data[8*d +: 8]}.
  - Config jobs: the same {0x0, addr, data} word replicated for every device.
  - Device NUM_DEVICES-1 occupies the MSBs.
- SHIFT: cs=0 for the whole state; the word is sent MSB first.
  - Per bit: mosi is set while sck=0, then sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles.
  - The first bit is valid in the first SHIFT cycle. Total SHIFT length is NUM_DEVICES*32*CLK_DIV cycles.
  - After the last high phase: sck=0, mosi=0.
- GAP: cs=1 (the rising CS latches data) for 2*CLK_DIV cycles, then LOAD for the next job or end of frame.
  - Cycles per job = 2 + 32*NUM_DEVICES*CLK_DIV + 2*CLK_DIV.
- End of frame: last_intensity=cur_int, frame_done=1 for exactly 1 cycle, busy=0 in the same cycle, state=IDLE. A new start is accepted the following cycle.
- enable deasserted mid-frame: the current job finishes SHIFT and GAP, then IDLE with busy=0. No frame_done; init_needed is unchanged.
- intensity changes mid-frame: no effect until the next start.
- reset mid-transaction: outputs return to reset values immediately; the next frame re-runs init.
- Bit/shift counters sized for NUM_DEVICES*16 bits and CLK_DIV without overflow. No combinational path from inputs to pad outputs.

Test Plan:
- NUM_DEVICES=2, CLK_DIV=2: reset, start, row_data = row-dependent pattern.
  - Required: 13 CS-low windows (5 init + 8 rows), each with 32 SCK rising edges and 128 cycles low.
  - First window decodes 0x0C01_0C01; row 3 window decodes {0x04,data[15:8],0x04,data[7:0]}.
  - frame_done pulses once; total length 13*(2+128+4) = 1742 cycles.
- Second start with unchanged intensity -> only 8 row windows. Change intensity to 0x5 and start -> 9 windows, the first decoding 0x0A05_0A05.
- reinit pulse while busy -> the current frame is unaffected; the next frame has 13 windows.
- start pulse while busy, and start with enable=0 -> ignored; busy and window count unchanged.
- Deassert enable during row 2 SHIFT -> row 2 completes with cs returning to 1; busy falls; no frame_done.
- Assert reset mid-SHIFT -> cs=1, sck=0, mosi=0 the same cycle; the next start issues the full 5-word init again.
